// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle for the bit-serial adder: operands and start in, busy/done and registered sum out.
// The master drives operands and start; the slave (the adder) returns status and result.
interface serial_adder_ctrl_if #(
   parameter int WIDTH = 8
) ();
   logic             i_start;
   logic [WIDTH-1:0] i_a;
   logic [WIDTH-1:0] i_b;
   logic             i_ci;
   logic             o_busy;
   logic             o_done;
   logic [WIDTH-1:0] o_sum;
   logic             o_co;

   modport master (
      output i_start, i_a, i_b, i_ci,
      input  o_busy, o_done, o_sum, o_co
   );

   modport slave (
      input  i_start, i_a, i_b, i_ci,
      output o_busy, o_done, o_sum, o_co
   );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder sharing one full-adder cell, LSB first; result valid WIDTH+1 edges after start.
// Start is accepted only in IDLE; requests during RUN/DONE are dropped, not queued.
module fa_dataflow (
   input  logic a_i,
   input  logic b_i,
   input  logic ci_i,
   output logic s_o,
   output logic co_o
);
   assign s_o  = a_i ^ b_i ^ ci_i;
   assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   serial_adder_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [WIDTH-1:0] ps_q, ps_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             c_q, c_d;
   logic             co_q, co_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fa_s, fa_co;
   logic [WIDTH-1:0] ps_shift;

   fa_dataflow u_fa (
      .a_i  (sa_q[0]),
      .b_i  (sb_q[0]),
      .ci_i (c_q),
      .s_o  (fa_s),
      .co_o (fa_co)
   );

   // New sum bit enters at the MSB so the LSB-first result lands in place after WIDTH shifts.
   generate
      if (WIDTH == 1) begin : g_ps_w1
         assign ps_shift = fa_s;
      end else begin : g_ps_wn
         assign ps_shift = {fa_s, ps_q[WIDTH-1:1]};
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      ps_d    = ps_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      co_d    = co_q;
      case (state_q)
         IDLE: begin
            if (bus.i_start) begin
               sa_d    = bus.i_a;
               sb_d    = bus.i_b;
               c_d     = bus.i_ci;
               ps_d    = '0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sa_d  = sa_q >> 1;
            sb_d  = sb_q >> 1;
            ps_d  = ps_shift;
            c_d   = fa_co;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               sum_d   = ps_shift;
               co_d    = fa_co;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         ps_q    <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         co_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         ps_q    <= ps_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         co_q    <= co_d;
      end
   end

   assign bus.o_busy = (state_q == RUN);
   assign bus.o_done = (state_q == DONE);
   assign bus.o_sum  = sum_q;
   assign bus.o_co   = co_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1: cycle model of the handshake plus a result scoreboard.
// Expected sums are pushed on start acceptance and popped when the model reaches DONE.
module tb_serial_adder_ctrl;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic mon_en = 1'b0;
   always #5 clk = ~clk;

   serial_adder_ctrl_if #(.WIDTH(8)) if0 ();
   serial_adder_ctrl_if #(.WIDTH(1)) if1 ();

   serial_adder_ctrl #(.WIDTH(8), .CNT_W(6)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if0));
   serial_adder_ctrl #(.WIDTH(1), .CNT_W(2)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   logic        st_a     [2];
   logic [32:0] opsum_a  [2];
   logic        obs_busy [2];
   logic        obs_done [2];
   logic [32:0] obs_res  [2];

   always_comb begin
      st_a[0]     = if0.i_start;
      st_a[1]     = if1.i_start;
      opsum_a[0]  = 33'(if0.i_a) + 33'(if0.i_b) + 33'(if0.i_ci);
      opsum_a[1]  = 33'(if1.i_a) + 33'(if1.i_b) + 33'(if1.i_ci);
      obs_busy[0] = if0.o_busy;
      obs_busy[1] = if1.o_busy;
      obs_done[0] = if0.o_done;
      obs_done[1] = if1.o_done;
      obs_res[0]  = 33'({if0.o_co, if0.o_sum});
      obs_res[1]  = 33'({if1.o_co, if1.o_sum});
   end

   // Reference model: 0=IDLE 1=RUN 2=DONE; mres is the result the outputs must hold.
   int          ms   [2];
   int          mcnt [2];
   logic [32:0] mres [2];
   logic [32:0] q0[$];
   logic [32:0] q1[$];

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            ms[k]   <= 0;
            mcnt[k] <= 0;
            mres[k] <= '0;
         end else begin
            case (ms[k])
               0: if (st_a[k]) begin
                     ms[k]   <= 1;
                     mcnt[k] <= 0;
                     if (k == 0) q0.push_back(opsum_a[0]);
                     else        q1.push_back(opsum_a[1]);
                  end
               1: begin
                     if (mcnt[k] == ((k == 0) ? 8 : 1) - 1) begin
                        ms[k]   <= 2;
                        mres[k] <= (k == 0) ? q0[0] : q1[0];
                     end
                     mcnt[k] <= mcnt[k] + 1;
                  end
               default: ms[k] <= 0;
            endcase
         end
      end
      if (!rst_n) begin
         q0.delete();
         q1.delete();
      end
   end

   int   done_cnt  [2] = '{0, 0};
   logic prev_done [2] = '{1'b0, 1'b0};

   always @(negedge clk) begin
      if (mon_en) begin
         for (int k = 0; k < 2; k++) begin
            chk("busy", 64'(obs_busy[k]), 64'(ms[k] == 1));
            chk("done", 64'(obs_done[k]), 64'(ms[k] == 2));
            chk("busy_done_excl", 64'(obs_busy[k] & obs_done[k]), 64'(0));
            chk("done_consecutive", 64'(obs_done[k] & prev_done[k]), 64'(0));
            chk("result_hold", 64'(obs_res[k]), 64'(mres[k]));
            if (ms[k] == 2) begin
               if (k == 0) begin
                  if (q0.size() == 0) chk("sb_underflow_w8", 64'(1), 64'(0));
                  else                chk("sb_result_w8", 64'(obs_res[0]), 64'(q0.pop_front()));
               end else begin
                  if (q1.size() == 0) chk("sb_underflow_w1", 64'(1), 64'(0));
                  else                chk("sb_result_w1", 64'(obs_res[1]), 64'(q1.pop_front()));
               end
            end
            if (obs_done[k]) done_cnt[k] <= done_cnt[k] + 1;
            prev_done[k] <= obs_done[k];
         end
      end
   end

   task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic ci);
      @(negedge clk);
      if0.i_start = 1'b1;
      if0.i_a     = a;
      if0.i_b     = b;
      if0.i_ci    = ci;
      @(negedge clk);
      if0.i_start = 1'b0;
      if0.i_a     = 8'($urandom);
      if0.i_b     = 8'($urandom);
      if0.i_ci    = 1'($urandom);
   endtask

   task automatic start1(input logic a, input logic b, input logic ci);
      @(negedge clk);
      if1.i_start = 1'b1;
      if1.i_a     = a;
      if1.i_b     = b;
      if1.i_ci    = ci;
      @(negedge clk);
      if1.i_start = 1'b0;
      if1.i_a     = 1'($urandom);
      if1.i_b     = 1'($urandom);
      if1.i_ci    = 1'($urandom);
   endtask

   task automatic wait_idle(input int k);
      int n = 0;
      while (!(ms[k] == 0 && !obs_busy[k] && !obs_done[k]) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("wait_idle_timeout", 64'(1), 64'(0));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: simulation did not complete, %0d miscompares so far", n_err);
      $fatal(1, "timeout");
   end

   initial begin
      int d0;
      if0.i_start = 1'b0; if0.i_a = '0; if0.i_b = '0; if0.i_ci = 1'b0;
      if1.i_start = 1'b0; if1.i_a = '0; if1.i_b = '0; if1.i_ci = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      mon_en = 1'b1;
      @(negedge clk);
      chk("reset_sum", 64'(if0.o_sum), 64'(0));
      chk("reset_co", 64'(if0.o_co), 64'(0));
      chk("reset_busy", 64'(if0.o_busy), 64'(0));
      chk("reset_done", 64'(if0.o_done), 64'(0));
      rst_n = 1'b1;

      start8(8'h3C, 8'h5A, 1'b0);
      wait_idle(0);
      chk("add_3c_5a", 64'(obs_res[0]), 64'h096);

      start8(8'hFF, 8'h01, 1'b0);
      wait_idle(0);
      chk("add_ff_01", 64'(obs_res[0]), 64'h100);

      start8(8'hFF, 8'hFF, 1'b1);
      wait_idle(0);
      chk("add_ff_ff_ci", 64'(obs_res[0]), 64'h1FF);

      // Start re-pulsed with new operands while RUN is in progress.
      d0 = done_cnt[0];
      start8(8'h12, 8'h34, 1'b0);
      @(negedge clk);
      if0.i_start = 1'b1; if0.i_a = 8'hFF; if0.i_b = 8'hFF; if0.i_ci = 1'b1;
      repeat (2) @(negedge clk);
      if0.i_start = 1'b0;
      wait_idle(0);
      chk("repulse_sum", 64'(obs_res[0]), 64'h046);
      chk("repulse_done_count", 64'(done_cnt[0] - d0), 64'(1));

      // Reset asserted for one edge during the 4th RUN cycle.
      d0 = done_cnt[0];
      start8(8'hAA, 8'h55, 1'b1);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrun_rst_sum", 64'(if0.o_sum), 64'(0));
      chk("midrun_rst_co", 64'(if0.o_co), 64'(0));
      chk("midrun_rst_busy", 64'(if0.o_busy), 64'(0));
      chk("midrun_rst_done", 64'(if0.o_done), 64'(0));
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("midrun_rst_no_done", 64'(done_cnt[0] - d0), 64'(0));
      start8(8'h01, 8'h01, 1'b0);
      wait_idle(0);
      chk("after_rst_add", 64'(obs_res[0]), 64'h002);

      // Start held high: restarts every WIDTH+2 cycles.
      d0 = done_cnt[0];
      @(negedge clk);
      if0.i_start = 1'b1; if0.i_a = 8'h10; if0.i_b = 8'h20; if0.i_ci = 1'b0;
      repeat (40) @(negedge clk);
      if0.i_start = 1'b0;
      wait_idle(0);
      chk("held_start_dones", 64'(done_cnt[0] - d0), 64'(4));
      chk("held_start_sum", 64'(obs_res[0]), 64'h030);

      for (int i = 0; i < 600; i++) begin
         start8(8'($urandom), 8'($urandom), 1'($urandom));
         wait_idle(0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      for (int i = 0; i < 600; i++) begin
         start1(1'($urandom), 1'($urandom), 1'($urandom));
         wait_idle(1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (4) @(negedge clk);
      chk("sb_drain_w8", 64'(q0.size()), 64'(0));
      chk("sb_drain_w1", 64'(q1.size()), 64'(0));
      mon_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller that time-shares one 1-bit full-adder cell (fa_dataflow) to add two WIDTH-bit operands, LSB first, one bit per clock.
- Provides a start/busy/done handshake plus a registered result, so upstream logic gets a multi-bit add without instantiating WIDTH full adders.
- Intended as the sequencing layer above the existing full-adder cell in the arithmetic practice datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.
- CNT_W, 6, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- i_start  input  1  request; sampled only in IDLE
- i_a  input  WIDTH  operand A, captured on accepted start
- i_b  input  WIDTH  operand B, captured on accepted start
- i_ci  input  1  carry-in, captured on accepted start
- o_busy  output  1  high while in RUN
- o_done  output  1  one-cycle pulse, result valid
- o_sum  output  WIDTH  registered sum
- o_co  output  1  registered carry-out

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low. Every register updates only on rising clk; rst_n=0 at an edge overrides all other inputs.
- Reset values: state=IDLE, o_busy=0, o_done=0, o_sum=0, o_co=0, internal shift registers, carry flop and counter all 0.
- Datapath: shift regs sa, sb (WIDTH); carry flop c; partial-sum shift reg ps (WIDTH); counter cnt (CNT_W). Exactly one full-adder cell, with inputs sa[0], sb[0], c and outputs s, co.
- FSM states: IDLE, RUN, DONE. These are the only states. Encoding is free. Unreachable codes must go to IDLE.
- IDLE:
  - If i_start=1: load sa=i_a, sb=i_b, c=i_ci, ps=0, cnt=0; go to RUN.
  - Otherwise hold.
  - o_sum/o_co keep the previous result.
- RUN (o_busy=1), at each edge:
  - sa>>=1, sb>>=1 (zero fill).
  - ps = {s, ps[WIDTH-1:1]}; c=co; cnt=cnt+1.
  - When cnt==WIDTH-1 at the edge: the next state is DONE, and o_sum<={s, ps[WIDTH-1:1]}, o_co<=co are loaded at that same edge.
- DONE: o_done=1 for exactly this one cycle; o_busy=0. Next edge goes to IDLE unconditionally.
- Latency: the start is accepted at edge E. RUN occupies cycles E..E+WIDTH-1 (WIDTH cycles). o_done=1 in the cycle following edge E+WIDTH, and o_sum/o_co are valid from that cycle.
- Throughput: one add per WIDTH+2 cycles. i_start held high continuously restarts from IDLE every WIDTH+2 cycles.
- Result hold: o_sum/o_co change only at the RUN->DONE edge or on reset. They stay stable through IDLE and subsequent RUN until the next DONE.
- i_start in RUN or DONE: ignored, no queuing. i_a/i_b/i_ci changes after capture have no effect.
- Arithmetic: {o_co,o_sum} = i_a + i_b + i_ci, modulo 2^(WIDTH+1) (exact, no overflow loss).
- WIDTH=1: RUN lasts one cycle; same rules apply.
- Reset mid-RUN or in DONE: state goes to IDLE, all outputs zeroed, no o_done pulse, and the in-flight operation is discarded.
- o_done and o_busy are never high together. o_done is never high in consecutive cycles.

Test Plan:
- WIDTH=8, i_a=8'h3C, i_b=8'h5A, i_ci=0, start pulse -> o_busy high 8 cycles, o_done one cycle 9 edges after accept, o_sum=8'h96, o_co=0.
- i_a=8'hFF, i_b=8'h01, i_ci=0 -> o_sum=8'h00, o_co=1. Then i_a=8'hFF, i_b=8'hFF, i_ci=1 -> o_sum=8'hFF, o_co=1.
- Start accepted, then i_start re-pulsed and i_a/i_b changed during RUN -> result still from captured operands, and exactly one o_done.
- rst_n=0 for one edge on the 4th RUN cycle -> next cycle all outputs 0, state IDLE, no o_done. A new start afterwards completes normally (8'h01+8'h01 -> 8'h02, o_co=0).
- i_start held high with 8'h10+8'h20 -> o_done pulses every 10 cycles, o_sum=8'h30 each time, o_sum stable between pulses.
- Random regression (≥1000 vectors, WIDTH=8 and WIDTH=1) against a {co,sum}=a+b+ci model; check latency and the busy/done exclusivity invariants on every cycle.
